// File: rtl/i_value.sv
// Operand width normaliser: trims a 64-bit value to 8/16/32/64 bits,
// zero- or sign-extends it, and registers the result with a lossy flag.
module i_value #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] value,
    input  logic [1:0]      size,
    input  logic            sign_extend,
    output logic [XLEN-1:0] result,
    output logic            out_valid,
    output logic            lossy
);

    typedef enum logic [1:0] {
        BITS_8  = 2'b00,
        BITS_16 = 2'b01,
        BITS_32 = 2'b10,
        BITS_64 = 2'b11
    } size_e;

    logic [XLEN-1:0] result_d, result_q;
    logic            lossy_d, lossy_q;
    logic            valid_q;
    size_e           size_s;

    assign size_s = size_e'(size);

    always_comb begin
        result_d = value;
        unique case (size_s)
            BITS_8: begin
                result_d = {{(XLEN-8){sign_extend & value[7]}},
                            value[7:0]};
            end
            BITS_16: begin
                result_d = {{(XLEN-16){sign_extend & value[15]}},
                            value[15:0]};
            end
            BITS_32: begin
                result_d = {{(XLEN-32){sign_extend & value[31]}},
                            value[31:0]};
            end
            BITS_64: begin
                result_d = value;
            end
        endcase
        lossy_d = (result_d != value);
    end

    // Data and flag only update on accepted operands; valid tracks every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            lossy_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                lossy_q  <= lossy_d;
            end
        end
    end

    assign result    = result_q;
    assign lossy     = lossy_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_i_value.sv
// Directed bench for i_value: width/extension vectors, streaming,
// hold on idle and asynchronous reset behaviour.
module tb_i_value;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] value;
    logic [1:0]  size;
    logic        sign_extend;
    logic [63:0] result;
    logic        out_valid;
    logic        lossy;

    int n_tests;
    int n_fail;

    localparam logic [1:0] B8  = 2'b00;
    localparam logic [1:0] B16 = 2'b01;
    localparam logic [1:0] B32 = 2'b10;
    localparam logic [1:0] B64 = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    i_value #(.XLEN(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .value       (value),
        .size        (size),
        .sign_extend (sign_extend),
        .result      (result),
        .out_valid   (out_valid),
        .lossy       (lossy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic        v,
                         input logic [63:0] val,
                         input logic [1:0]  sz,
                         input logic        se);
        @(negedge clk);
        in_valid    = v;
        value       = val;
        size        = sz;
        sign_extend = se;
    endtask

    task automatic run(input string       tag,
                       input logic [63:0] val,
                       input logic [1:0]  sz,
                       input logic        se,
                       input logic [63:0] exp_r,
                       input logic        exp_l);
        drive(1'b1, val, sz, se);
        @(posedge clk);
        #1;
        check({tag, ".res"}, result, exp_r);
        check({tag, ".lossy"}, 64'(lossy), 64'(exp_l));
        check({tag, ".vld"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        value       = '0;
        size        = B8;
        sign_extend = 1'b0;
        #2;
        check("rst.res", result, 64'd0);
        check("rst.vld", 64'(out_valid), 64'd0);
        check("rst.lossy", 64'(lossy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("b8z", ONES, B8, 1'b0, 64'h0000_0000_0000_00FF, 1'b1);
        run("b8s", ONES, B8, 1'b1, ONES, 1'b0);
        run("one8", 64'h1, B8, 1'b1, 64'h1, 1'b0);
        run("one16", 64'h1, B16, 1'b1, 64'h1, 1'b0);
        run("one32", 64'h1, B32, 1'b1, 64'h1, 1'b0);
        run("one64", 64'h1, B64, 1'b1, 64'h1, 1'b0);
        run("x80", 64'h80, B8, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        run("x80z", 64'h80, B8, 1'b0, 64'h80, 1'b0);
        run("b16z", ONES, B16, 1'b0, 64'h0000_0000_0000_FFFF, 1'b1);
        run("b32z", ONES, B32, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        run("b16s", ONES, B16, 1'b1, ONES, 1'b0);
        run("b32s", ONES, B32, 1'b1, ONES, 1'b0);
        run("b64z", ONES, B64, 1'b0, ONES, 1'b0);
        run("b64s", ONES, B64, 1'b1, ONES, 1'b0);
        run("b32m", 64'h1234_5678_9ABC_DEF0, B32, 1'b1,
            64'hFFFF_FFFF_9ABC_DEF0, 1'b1);
        run("b16p", 64'h1234_5678_9ABC_7EF0, B16, 1'b1,
            64'h0000_0000_0000_7EF0, 1'b1);
        run("b64p", 64'h1234_5678_9ABC_DEF0, B64, 1'b0,
            64'h1234_5678_9ABC_DEF0, 1'b0);

        // Back-to-back stream, each checked one cycle later.
        run("s0", 64'h0000_0000_0000_8001, B16, 1'b1,
            64'hFFFF_FFFF_FFFF_8001, 1'b1);
        run("s1", 64'hAAAA_AAAA_5555_5555, B32, 1'b1,
            64'h0000_0000_5555_5555, 1'b1);
        run("s2", 64'h0000_0000_0000_007F, B8, 1'b1,
            64'h0000_0000_0000_007F, 1'b0);
        run("s3", 64'hDEAD_BEEF_CAFE_F00D, B8, 1'b0,
            64'h0000_0000_0000_000D, 1'b1);

        // Idle: valid drops, data and flag hold.
        drive(1'b0, ONES, B64, 1'b1);
        @(posedge clk);
        #1;
        check("idle.vld", 64'(out_valid), 64'd0);
        check("idle.res", result, 64'h0000_0000_0000_000D);
        check("idle.lossy", 64'(lossy), 64'd1);
        @(posedge clk);
        #1;
        check("idle2.res", result, 64'h0000_0000_0000_000D);

        // Async reset mid-cycle while out_valid is high.
        run("pre", ONES, B8, 1'b0, 64'h0000_0000_0000_00FF, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.res", result, 64'd0);
        check("arst.vld", 64'(out_valid), 64'd0);
        check("arst.lossy", 64'(lossy), 64'd0);
        drive(1'b1, ONES, B16, 1'b0);
        @(posedge clk);
        #1;
        check("hold.res", result, 64'd0);
        check("hold.vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel.res", result, 64'h0000_0000_0000_FFFF);
        check("rel.vld", 64'(out_valid), 64'd1);
        check("rel.lossy", 64'(lossy), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
